// File: rtl/grand_adder_pipe_pkg.sv
// Shared widths and the stage-1 payload for the FMA grand-adder pipe.
// Widths are fixed for the single-precision build (M=23).
package ga_pkg;
  localparam int GA_MANT  = 23;
  localparam int GA_TAG_W = 4;
  localparam int CSA_W    = 2*GA_MANT + 2;
  localparam int HI_W     = GA_MANT + 4;
  localparam int RES_W    = 3*GA_MANT + 5;
  localparam int LZC_W    = $clog2(RES_W + 1);

  // low_si holds bits [2M+2:1] of the inverted low sum; bit 0 is always zero.
  typedef struct packed {
    logic             low_c;
    logic [CSA_W-1:0] low_s;
    logic             low_ci;
    logic [CSA_W-1:0] low_si;
    logic             sub_sign;
    logic             exp_mv_sign;
    logic             mv_halt;
    logic             sign_aligned;
    logic             minus_ok;
    logic [HI_W-1:0]  a_high;
  } ga_s1_t;
endpackage

// File: rtl/grand_adder_pipe_if.sv
// Handshake and data bundle around the grand-adder pipe.
// slave = the pipe itself, master = the producer/consumer side.
interface grand_adder_pipe_if #(
  parameter int PARM_MANT = ga_pkg::GA_MANT,
  parameter int TAG_W     = ga_pkg::GA_TAG_W
);
  localparam int CW = 2*PARM_MANT + 2;
  localparam int HW = PARM_MANT + 4;
  localparam int RW = 3*PARM_MANT + 5;

  logic             valid_i;
  logic             ready_o;
  logic [TAG_W-1:0] tag_i;
  logic [CW-1:0]    csa_sum_i;
  logic [CW-1:0]    csa_carry_i;
  logic             sub_sign_i;
  logic             wal_sup_sign_ext_i;
  logic             wal_sum_adj_msb_i;
  logic [1:0]       wal_carry_adj_2msb_i;
  logic             exp_mv_sign_i;
  logic             mv_halt_i;
  logic             sign_aligned_i;
  logic [HW-1:0]    a_mant_aligned_high_i;
  logic             b_inf_i, c_inf_i, b_zero_i, c_zero_i, b_nan_i, c_nan_i;
  logic             valid_o;
  logic             ready_i;
  logic [TAG_W-1:0] tag_o;
  logic [RW-1:0]    pos_sum_o;
  logic             adder_sign_o;
  logic             sign_flip_o;
  logic             minus_sticky_o;
`ifdef GA_LZC_EN
  logic [$clog2(RW+1)-1:0] lzc_o;
`endif

  modport slave (
    input  valid_i, tag_i, csa_sum_i, csa_carry_i, sub_sign_i, wal_sup_sign_ext_i,
           wal_sum_adj_msb_i, wal_carry_adj_2msb_i, exp_mv_sign_i, mv_halt_i, sign_aligned_i,
           a_mant_aligned_high_i, b_inf_i, c_inf_i, b_zero_i, c_zero_i, b_nan_i, c_nan_i, ready_i,
    output ready_o, valid_o, tag_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
`ifdef GA_LZC_EN
    , output lzc_o
`endif
  );

  modport master (
    output valid_i, tag_i, csa_sum_i, csa_carry_i, sub_sign_i, wal_sup_sign_ext_i,
           wal_sum_adj_msb_i, wal_carry_adj_2msb_i, exp_mv_sign_i, mv_halt_i, sign_aligned_i,
           a_mant_aligned_high_i, b_inf_i, c_inf_i, b_zero_i, c_zero_i, b_nan_i, c_nan_i, ready_i,
    input  ready_o, valid_o, tag_o, pos_sum_o, adder_sign_o, sign_flip_o, minus_sticky_o
`ifdef GA_LZC_EN
    , input lzc_o
`endif
  );
endinterface

// File: rtl/grand_adder_pipe_lzc.sv
// ga_lzc: leading-zero count of a W-bit vector, W when the vector is zero.
// Latency: combinational. Backpressure: none (pure function).
// Only present when GA_LZC_EN is defined.
`ifdef GA_LZC_EN
module ga_lzc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);
  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) cnt = CW'(W - 1 - i);
    end
  end
endmodule
`endif

// File: rtl/grand_adder_pipe.sv
// Grand adder: CSA sum/carry add with end-around correction, high-half inc/complement, result select.
// Latency: 2 cycles accept-to-valid_o, 1 op/cycle. Backpressure: ready_i stalls stage 2, then stage 1.
// Option GA_LZC_EN adds a registered leading-zero count of pos_sum_o on lzc_o.
module grand_adder_pipe
  import ga_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  grand_adder_pipe_if.slave  bus
);
  localparam int LOW_W   = CSA_W + 1;
  localparam int HI_LO_W = HI_W - 1;

  logic                s1_valid, s2_valid, s2_ready, in_xfer, mid_xfer;
  logic                corr, postcor, minus_ok;
  logic [LOW_W-1:0]    low, inv_hi;
  ga_s1_t              s1_d, s1_q;
  logic [GA_TAG_W-1:0] s1_tag;
  logic [HI_W-1:0]     hs, sub_hi;
  logic [HI_LO_W-1:0]  hs_inv;
  logic [RES_W-1:0]    pos_d;
  logic                sign_d;

  assign s2_ready    = !s2_valid || bus.ready_i;
  assign bus.ready_o = !s1_valid || s2_ready;
  assign in_xfer     = bus.valid_i && bus.ready_o;
  assign mid_xfer    = s1_valid && s2_ready;
  assign bus.valid_o = s2_valid;

  always_comb begin
    corr     = bus.wal_sup_sign_ext_i | bus.wal_carry_adj_2msb_i[1]
             | (bus.wal_sum_adj_msb_i & bus.wal_carry_adj_2msb_i[0]);
    postcor  = bus.exp_mv_sign_i ? 1'b0 : (~corr ^ bus.csa_carry_i[CSA_W-1]);
    minus_ok = ~|{bus.b_inf_i, bus.c_inf_i, bus.b_zero_i, bus.c_zero_i, bus.b_nan_i, bus.c_nan_i};
    low      = {1'b0, bus.csa_sum_i} + {postcor, bus.csa_carry_i[CSA_W-2:0], bus.sub_sign_i};
    // Both inverted operands end in 1 and the +2 is even, so the full sum is this value << 1.
    inv_hi   = {1'b1, ~bus.csa_sum_i} + {~postcor, ~bus.csa_carry_i[CSA_W-2:0], ~bus.sub_sign_i}
             + LOW_W'(2);
    s1_d              = '0;
    s1_d.low_c        = low[CSA_W];
    s1_d.low_s        = low[CSA_W-1:0];
    s1_d.low_ci       = inv_hi[CSA_W];
    s1_d.low_si       = inv_hi[CSA_W-1:0];
    s1_d.sub_sign     = bus.sub_sign_i;
    s1_d.exp_mv_sign  = bus.exp_mv_sign_i;
    s1_d.mv_halt      = bus.mv_halt_i;
    s1_d.sign_aligned = bus.sign_aligned_i;
    s1_d.minus_ok     = minus_ok;
    s1_d.a_high       = bus.a_mant_aligned_high_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush_i)          s1_valid <= 1'b0;
      else if (bus.ready_o) s1_valid <= bus.valid_i;
      if (in_xfer) begin
        s1_q   <= s1_d;
        s1_tag <= bus.tag_i;
      end
    end
  end

  always_comb begin
    hs     = s1_q.a_high + HI_W'(s1_q.low_c);
    hs_inv = ~s1_q.a_high[HI_LO_W-1:0] - HI_LO_W'(!s1_q.low_ci);
    sub_hi = {s1_q.a_high[HI_LO_W-1:0], 1'b0} - HI_W'(s1_q.minus_ok);
    if (s1_q.mv_halt)
      pos_d = RES_W'(s1_q.low_s);
    else if (s1_q.exp_mv_sign)
      pos_d = s1_q.sub_sign ? (RES_W'(sub_hi) << (CSA_W - 1))
                            : {s1_q.a_high[HI_LO_W-1:0], {CSA_W{1'b0}}};
    else if (hs[HI_W-1])
      pos_d = {hs_inv, s1_q.low_si};
    else
      pos_d = {hs[HI_LO_W-1:0], s1_q.low_s};
    sign_d = s1_q.exp_mv_sign ? s1_q.sign_aligned : (hs[HI_W-1] ^ s1_q.sign_aligned);
  end

`ifdef GA_LZC_EN
  logic [LZC_W-1:0] lzc_d;
  ga_lzc #(.W(RES_W), .CW(LZC_W)) u_lzc (.vec(pos_d), .cnt(lzc_d));
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid           <= 1'b0;
      bus.tag_o          <= '0;
      bus.pos_sum_o      <= '0;
      bus.adder_sign_o   <= 1'b0;
      bus.sign_flip_o    <= 1'b0;
      bus.minus_sticky_o <= 1'b0;
`ifdef GA_LZC_EN
      bus.lzc_o          <= '0;
`endif
    end else begin
      if (flush_i)       s2_valid <= 1'b0;
      else if (s2_ready) s2_valid <= s1_valid;
      if (mid_xfer) begin
        bus.tag_o          <= s1_tag;
        bus.pos_sum_o      <= pos_d;
        bus.adder_sign_o   <= sign_d;
        bus.sign_flip_o    <= hs[HI_W-1];
        bus.minus_sticky_o <= s1_q.exp_mv_sign & s1_q.minus_ok;
`ifdef GA_LZC_EN
        bus.lzc_o          <= lzc_d;
`endif
      end
    end
  end
endmodule

// File: tb/tb_grand_adder_pipe.sv
// Bench for grand_adder_pipe: directed vector table, reset/flush sequences, stalled random stream.
module tb_grand_adder_pipe;
  import ga_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic [47:0] sum, carry;
    logic        sub, sup, smsb;
    logic [1:0]  c2;
    logic        ems, halt, sa;
    logic [26:0] ah;
    logic [5:0]  flags;  // {b_inf, c_inf, b_zero, c_zero, b_nan, c_nan}
  } op_t;

  typedef struct {
    logic [73:0] pos;
    logic        sign, flip, ms;
    logic [6:0]  lzc;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  grand_adder_pipe_if bus();
  grand_adder_pipe dut (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus));

  int total = 0, bad = 0;
  vec_t vecs[8];
  op_t  rops[8];
  res_t rexp[8];

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic op_t blank(input logic [3:0] t);
    op_t o;
    o.tag = t; o.sum = '0; o.carry = '0; o.sub = 0; o.sup = 0; o.smsb = 0; o.c2 = '0;
    o.ems = 0; o.halt = 0; o.sa = 0; o.ah = '0; o.flags = '0;
    return o;
  endfunction

  function automatic res_t mkres(input logic [73:0] p, input logic s, input logic f,
                                 input logic m, input logic [6:0] z);
    res_t r;
    r.pos = p; r.sign = s; r.flip = f; r.ms = m; r.lzc = z;
    return r;
  endfunction

  function automatic res_t model(input op_t o);
    logic        corr, pc, mok;
    logic [48:0] lo, li;
    logic [26:0] hs;
    logic [25:0] hinv;
    logic [73:0] p;
    res_t        r;
    corr = o.sup | o.c2[1] | (o.smsb & o.c2[0]);
    pc   = o.ems ? 1'b0 : (~corr ^ o.carry[47]);
    lo   = {1'b0, o.sum} + {pc, o.carry[46:0], o.sub};
    li   = 49'((50'd2 + {1'b1, ~o.sum, 1'b1} + {~pc, ~o.carry[46:0], ~o.sub, 1'b1}) >> 1);
    mok  = ~|o.flags;
    hs   = lo[48] ? o.ah + 27'd1 : o.ah;
    hinv = li[48] ? ~o.ah[25:0] : ~o.ah[25:0] - 26'd1;
    if (o.halt)       p = 74'(lo[47:0]);
    else if (o.ems)   p = o.sub ? (74'({o.ah[25:0], 1'b0} - 27'(mok)) << 47) : {o.ah[25:0], 48'd0};
    else if (hs[26])  p = {hinv, li[47:0]};
    else              p = {hs[25:0], lo[47:0]};
    r.pos = p; r.sign = o.ems ? o.sa : (hs[26] ^ o.sa); r.flip = hs[26]; r.ms = o.ems & mok;
    r.lzc = 7'd74;
    for (int i = 0; i < 74; i++) if (p[i]) r.lzc = 7'(73 - i);
    return r;
  endfunction

  task automatic drive(input op_t o, input logic v);
    bus.valid_i = v; bus.tag_i = o.tag; bus.csa_sum_i = o.sum; bus.csa_carry_i = o.carry;
    bus.sub_sign_i = o.sub; bus.wal_sup_sign_ext_i = o.sup; bus.wal_sum_adj_msb_i = o.smsb;
    bus.wal_carry_adj_2msb_i = o.c2; bus.exp_mv_sign_i = o.ems; bus.mv_halt_i = o.halt;
    bus.sign_aligned_i = o.sa; bus.a_mant_aligned_high_i = o.ah;
    {bus.b_inf_i, bus.c_inf_i, bus.b_zero_i, bus.c_zero_i, bus.b_nan_i, bus.c_nan_i} = o.flags;
  endtask

  task automatic check_res(input string nm, input logic [3:0] t, input res_t e);
    chk({nm, ".tag"},  74'(bus.tag_o), 74'(t));
    chk({nm, ".pos"},  bus.pos_sum_o, e.pos);
    chk({nm, ".sign"}, 74'(bus.adder_sign_o), 74'(e.sign));
    chk({nm, ".flip"}, 74'(bus.sign_flip_o), 74'(e.flip));
    chk({nm, ".ms"},   74'(bus.minus_sticky_o), 74'(e.ms));
`ifdef GA_LZC_EN
    chk({nm, ".lzc"},  74'(bus.lzc_o), 74'(e.lzc));
`endif
  endtask

  initial begin
    int sent, got, seen;
    logic held;
    logic [3:0] htag;
    logic [73:0] hpos;

    // Hand-computed vectors (M=23).
    vecs[0].op = blank(4'd7); vecs[0].op.sum = 48'd5; vecs[0].op.carry = 48'd3;
    vecs[0].op.sup = 1; vecs[0].op.halt = 1;
    vecs[0].exp = mkres(74'd11, 0, 0, 0, 7'd70);
    vecs[1].op = blank(4'd1); vecs[1].op.ems = 1; vecs[1].op.ah = 27'd1; vecs[1].op.sa = 1;
    vecs[1].op.flags = 6'b000001;
    vecs[1].exp = mkres(74'd1 << 48, 1, 0, 0, 7'd25);
    vecs[2].op = blank(4'd2); vecs[2].op.ems = 1; vecs[2].op.sub = 1; vecs[2].op.ah = 27'd1;
    vecs[2].exp = mkres(74'd1 << 47, 0, 0, 1, 7'd26);
    vecs[3].op = blank(4'd3); vecs[3].op.ems = 1; vecs[3].op.sub = 1; vecs[3].op.ah = 27'd1;
    vecs[3].op.flags = 6'b001000;
    vecs[3].exp = mkres(74'd2 << 47, 0, 0, 0, 7'd25);
    vecs[4].op = blank(4'd4); vecs[4].op.sum = 48'd100; vecs[4].op.carry = 48'd20;
    vecs[4].op.ah = 27'd5; vecs[4].op.sa = 1;
    vecs[4].exp = mkres((74'd6 << 48) | 74'd140, 1, 0, 0, 7'd23);
    vecs[5].op = blank(4'd5); vecs[5].op.sup = 1; vecs[5].op.ah = 27'h4000000;
    vecs[5].exp = mkres({26'h3FFFFFE, 48'd0}, 1, 1, 0, 7'd0);
    vecs[6].op = blank(4'd6); vecs[6].op.halt = 1; vecs[6].op.sum = 48'hFFFF_FFFF_FFFF;
    vecs[6].op.carry = 48'h8000_0000_0001; vecs[6].op.sub = 1; vecs[6].op.sa = 1;
    vecs[6].exp = mkres(74'd2, 1, 0, 0, 7'd72);
    vecs[7].op = blank(4'd8); vecs[7].op.halt = 1; vecs[7].op.sup = 1;
    vecs[7].exp = mkres(74'd0, 0, 0, 0, 7'd74);

    bus.ready_i = 1'b1;
    drive(blank(4'd0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid_o", 74'(bus.valid_o), 74'd0);
    check_res("reset", 4'd0, mkres(74'd0, 0, 0, 0, 7'd0));
    rst_n = 1'b1;
    #1;
    chk("reset.ready_o", 74'(bus.ready_o), 74'd1);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, 1'b1);
      @(posedge clk); #1;
      drive(blank(4'd0), 1'b0);
      chk("vec.lat1_valid", 74'(bus.valid_o), 74'd0);
      @(posedge clk); #1;
      chk("vec.lat2_valid", 74'(bus.valid_o), 74'd1);
      check_res($sformatf("vec%0d", i), vecs[i].op.tag, vecs[i].exp);
    end
    @(posedge clk); #1;

    // Reset with two ops in flight.
    bus.ready_i = 1'b0;
    drive(vecs[1].op, 1'b1);
    @(posedge clk); #1;
    drive(vecs[2].op, 1'b1);
    @(posedge clk); #1;
    drive(blank(4'd0), 1'b0);
    chk("midrst.full_valid", 74'(bus.valid_o), 74'd1);
    chk("midrst.full_ready", 74'(bus.ready_o), 74'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.valid_o", 74'(bus.valid_o), 74'd0);
    check_res("midrst", 4'd0, mkres(74'd0, 0, 0, 0, 7'd0));
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    chk("midrst.ready_o", 74'(bus.ready_o), 74'd1);
    @(posedge clk); #1;
    chk("midrst.drained", 74'(bus.valid_o), 74'd0);

    // Back-to-back random stream with ready_i toggling 1,0,1,0...
    for (int k = 0; k < 8; k++) begin
      rops[k] = blank(4'(k));
      rops[k].sum   = 48'({$urandom(), $urandom()});
      rops[k].carry = 48'({$urandom(), $urandom()});
      rops[k].sub   = 1'($urandom_range(0, 1));
      rops[k].sup   = 1'($urandom_range(0, 1));
      rops[k].smsb  = 1'($urandom_range(0, 1));
      rops[k].c2    = 2'($urandom_range(0, 3));
      rops[k].sa    = 1'($urandom_range(0, 1));
      rops[k].ah    = 27'($urandom());
      rops[k].halt  = ($urandom_range(0, 5) == 0);
      rops[k].ems   = ($urandom_range(0, 4) == 0);
      rops[k].flags = ($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
      rexp[k] = model(rops[k]);
    end
    sent = 0; got = 0; held = 1'b0; htag = '0; hpos = '0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      @(posedge clk); #1;
      bus.ready_i = ((cyc % 2) == 0);
      if (sent < 8) drive(rops[sent], 1'b1);
      else          drive(blank(4'd0), 1'b0);
      #2;
      if (held) begin
        chk("stall.valid", 74'(bus.valid_o), 74'd1);
        chk("stall.tag", 74'(bus.tag_o), 74'(htag));
        chk("stall.pos", bus.pos_sum_o, hpos);
      end
      if (bus.valid_o && bus.ready_i) begin
        check_res($sformatf("rnd%0d", got), 4'(got), rexp[got]);
        got++;
      end
      held = bus.valid_o && !bus.ready_i;
      htag = bus.tag_o;
      hpos = bus.pos_sum_o;
      if (bus.valid_i && bus.ready_o) sent++;
    end
    chk("rnd.count", 74'(got), 74'd8);
    @(posedge clk); #1;
    drive(blank(4'd0), 1'b0);
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rnd.no_extra", 74'(bus.valid_o), 74'd0);

    // Flush with both stages full, then flush of an op offered into an empty pipe.
    bus.ready_i = 1'b0;
    drive(blank(4'd10), 1'b1);
    @(posedge clk); #1;
    drive(blank(4'd11), 1'b1);
    @(posedge clk); #1;
    chk("flush.full", 74'(bus.valid_o), 74'd1);
    drive(blank(4'd12), 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush.valid_o", 74'(bus.valid_o), 74'd0);
    bus.ready_i = 1'b1;
    #1;
    chk("flush.ready_o", 74'(bus.ready_o), 74'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(vecs[4].op, 1'b1);
    bus.tag_i = 4'd13;
    @(posedge clk); #1;
    drive(blank(4'd0), 1'b0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.valid_o) begin
        chk("flush.tag", 74'(bus.tag_o), 74'd13);
        chk("flush.pos", bus.pos_sum_o, vecs[4].exp.pos);
        seen++;
      end
      @(posedge clk); #1;
    end
    chk("flush.seen", 74'(seen), 74'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
